// File: rtl/perip_bridge.sv
// perip_bridge: single-outstanding initiator from load/store stage to
// word-wide GPIO/timer register ports; partial stores become read-modify-write.
module perip_bridge #(
  parameter logic [3:0] GPIO_SEL  = 4'h2,
  parameter logic [3:0] TIMER_SEL = 4'h3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        gpio_we,
  output logic [31:0] gpio_addr,
  output logic [31:0] gpio_wdata,
  input  logic [31:0] gpio_rdata,
  output logic        timer_we,
  output logic [31:0] timer_addr,
  output logic [31:0] timer_wdata,
  input  logic [31:0] timer_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  state_t state, state_nx;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [3:0]  be_q;
  logic        gpio_q;
  logic        timer_q;
  logic        err_q;

  logic        hit_gpio, hit_timer;
  logic        req_err, accept;
  logic        go_err, go_ld, go_full, go_none, go_part;
  logic [31:0] rd_word, merged;

  assign hit_gpio  = (req_addr[31:28] == GPIO_SEL);
  assign hit_timer = (req_addr[31:28] == TIMER_SEL);
  assign req_err   = ~(hit_gpio | hit_timer) | (|req_addr[1:0]);
  assign accept    = req_valid & req_ready;

  // mutually exclusive request classes out of IDLE
  assign go_err  = req_err;
  assign go_ld   = ~req_err & ~req_we;
  assign go_full = ~req_err & req_we & (req_be == 4'hF);
  assign go_none = ~req_err & req_we & (req_be == 4'h0);
  assign go_part = ~req_err & req_we & ~go_full & ~go_none;

  assign rd_word = gpio_q ? gpio_rdata : timer_rdata;

  always_comb begin
    merged = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            go_err:  state_nx = RESP;
            go_ld:   state_nx = READ;
            go_full: state_nx = WRITE;
            go_none: state_nx = RESP;
            go_part: state_nx = READ;
            default: state_nx = IDLE;
          endcase
        end
      end
      READ:    state_nx = we_q ? WRITE : RESP;
      WRITE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      gpio_q  <= 1'b0;
      timer_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
      gpio_q  <= hit_gpio & ~req_err;
      timer_q <= hit_timer & ~req_err;
      err_q   <= req_err;
    end else if (state == READ) begin
      if (we_q) wdata_q <= merged;
      else      rdata_q <= rd_word;
    end
  end

  assign req_ready  = (state == IDLE) & ~rst;
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = (resp_valid & ~we_q & ~err_q) ? rdata_q : '0;

  assign gpio_we     = (state == WRITE) & gpio_q;
  assign timer_we    = (state == WRITE) & timer_q;
  assign gpio_addr   = addr_q;
  assign timer_addr  = addr_q;
  assign gpio_wdata  = wdata_q;
  assign timer_wdata = wdata_q;

endmodule

// File: doc/perip_bridge.md
# perip_bridge

Single-outstanding memory-mapped bus initiator between the core's load/store stage and the word-wide peripheral register ports (GPIO, timer). It accepts one request at a time over a valid/ready handshake, decodes the target from the address, drives the peripheral's `we`/`addr`/`wdata` and samples its combinational `rdata`. Byte-enabled stores are converted to read-modify-write, because peripherals accept only full-word writes.

## Interface
- `GPIO_SEL`, default 4'h2: `req_addr[31:28]` value that selects GPIO.
- `TIMER_SEL`, default 4'h3: `req_addr[31:28]` value that selects timer.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `req_valid`  in  1  core request present.
- `req_ready`  out  1  bridge can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address; must be word-aligned.
- `req_wdata`  in  32  store data, lane-aligned.
- `req_be`  in  4  store byte enables; ignored on loads.
- `resp_valid`  out  1  one-cycle pulse, response valid.
- `resp_rdata`  out  32  load data; 0 on stores and errors.
- `resp_err`  out  1  unmapped or misaligned access; qualified by `resp_valid`.
- `gpio_we`, `timer_we`  out  1  peripheral write strobe.
- `gpio_addr`, `timer_addr`  out  32  registered request address.
- `gpio_wdata`, `timer_wdata`  out  32  registered (merged) write data.
- `gpio_rdata`, `timer_rdata`  in  32  combinational peripheral read data.

## Operation
- States: IDLE, READ, WRITE, RESP.
- Acceptance: on `req_valid & req_ready` in IDLE, latch `req_we`, `req_addr`, `req_wdata`, `req_be` and the decoded select.
- Transitions out of IDLE:
  - Error: unmapped `req_addr[31:28]` or `req_addr[1:0] != 0` -> RESP with err = 1.
  - Load -> READ.
  - Store with `be == 4'hF` -> WRITE.
  - Store with `be == 4'h0` -> RESP; no peripheral access, err = 0.
  - Store with any other `be` -> READ.
- READ: sample the selected `*_rdata` at the end of the cycle into the data register.
  - Load -> RESP.
  - Partial store -> WRITE. Merged word: byte i = `be[i]` ? `req_wdata` byte i : read byte i.
- WRITE: assert the selected `*_we` for exactly one cycle with the registered address and data -> RESP.
- RESP:
  - `resp_valid` = 1 for one cycle.
  - `resp_rdata` = captured word for loads, 0 otherwise.
  - Then -> IDLE.
- There is no response backpressure; the core must take `resp_valid` in the cycle it is high.
- Both peripherals see the same `addr`/`wdata` registers; only the `we` of the selected peripheral is gated on. An unselected peripheral's `we` is never asserted.
- Reset values: state IDLE, `req_ready` 0 while `rst` is high and 1 from the first cycle after. All other outputs 0: `resp_*`, `*_we`, `*_addr`, `*_wdata`.
- Reset mid-transaction aborts it:
  - no `we` and no `resp_valid` are emitted for the aborted request;
  - already-completed peripheral writes are not undone.
- `req_valid` while not in IDLE is ignored; the core holds it until `req_ready`.

## Timing
- Cycle 0 is the accept edge. Latencies from accept to `resp_valid`:
  - Load: READ in cycle 1, `resp_valid` in cycle 2.
  - Full store: `we` in cycle 1, `resp_valid` in cycle 2.
  - Partial store: READ in cycle 1, `we` in cycle 2, `resp_valid` in cycle 3.
  - Error or be = 0 store: `resp_valid` in cycle 1.
- `req_ready` returns high the cycle after RESP. Back-to-back full-store throughput is 3 cycles per request.
- `*_addr` and `*_wdata` are stable from cycle 1 until the next accept. `*_rdata` is sampled only in READ.

## Test plan
- Full-word write: store `addr` 32'h2000_0000, `wdata` 32'h0000_000A, `be` 4'hF -> `gpio_we` = 1 for one cycle in cycle 1, `gpio_addr` 32'h2000_0000, `timer_we` stays 0; `resp_valid` in cycle 2 with err = 0.
- Load: `gpio_rdata` = 32'h1234_5678, load `addr` 32'h2000_0004 -> `resp_valid` in cycle 2, `resp_rdata` 32'h1234_5678, no `we`.
- Partial store: `timer_rdata` = 32'hAABB_CCDD, store `addr` 32'h3000_0000, `wdata` 32'h0000_00EE, `be` 4'h1 -> `timer_we` in cycle 2 with `timer_wdata` 32'hAABB_CCEE; `resp_valid` in cycle 3.
- Errors: load from 32'h5000_0000 and store to 32'h2000_0002 -> each gives `resp_valid` in cycle 1 with err = 1, `rdata` 0, no `we`. A store with `be` 4'h0 gives `resp_valid` in cycle 1 with err = 0.
- Back-to-back: `req_valid` held high for two full stores -> second accepted 3 cycles after the first; `req_ready` low in between; exactly two `we` pulses.
- Reset mid-operation: assert `rst` in cycle 1 of a partial store -> no `we`, no `resp_valid`; all outputs 0 and state IDLE after reset; a subsequent load completes normally.
